packet_loader: RTL and testbench

- Writer-side front end for the routing table. Accepts 24-bit packets tagged with a destination slot id over a valid/ready handshake and buffers one packet per slot (6 slots).
- Once the set is complete, or on an explicit commit, presents all six packets in parallel and drives an active-low load strobe. This strobe feeds the table's bulk-load input (packet_in0..5 / clear_n).

---
 rtl/noc_pkg.sv | 16 +
 rtl/load_strobe_gen.sv | 42 ++++
 rtl/packet_loader.sv | 104 ++++++++++
 tb/tb_packet_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared constants and types for the routing-table loader.
package noc_pkg;

    localparam int unsigned PKT_W     = 24;
    localparam int unsigned NUM_SLOTS = 6;
    localparam int unsigned ID_W      = 4;

    typedef logic [PKT_W-1:0] packet_t;
    typedef logic [ID_W-1:0]  slot_id_t;

    typedef enum logic {
        FILL,
        LOAD
    } loader_state_t;

endpackage

// File: rtl/load_strobe_gen.sv
// Down-counter holding load_n low for LOAD_CYCLES cycles after a start request.
module load_strobe_gen #(
    parameter int unsigned LOAD_CYCLES = 1
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    output logic load_n,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = $clog2(LOAD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    logic [CW-1:0] count;

    // done marks the final strobe cycle so the owner can leave LOAD on that edge
    assign done = busy && (count == CNT_LAST);

    always_ff @(posedge clock) begin
        if (clear) begin
            count  <= '0;
            load_n <= 1'b1;
            busy   <= 1'b0;
        end else if (busy) begin
            if (done) begin
                count  <= '0;
                load_n <= 1'b1;
                busy   <= 1'b0;
            end else begin
                count <= count - CNT_LAST;
            end
        end else if (start) begin
            count  <= CNT_INIT;
            load_n <= 1'b0;
            busy   <= 1'b1;
        end
    end

endmodule

// File: rtl/packet_loader.sv
// Buffers one packet per destination slot and bulk-loads all slots into the routing table.
module packet_loader
    import noc_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ID_W-1:0]      in_id,
    input  logic [PKT_W-1:0]     in_packet,
    input  logic                 commit,
    output logic [PKT_W-1:0]     packet_out0,
    output logic [PKT_W-1:0]     packet_out1,
    output logic [PKT_W-1:0]     packet_out2,
    output logic [PKT_W-1:0]     packet_out3,
    output logic [PKT_W-1:0]     packet_out4,
    output logic [PKT_W-1:0]     packet_out5,
    output logic                 load_n,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 busy,
    output logic                 bad_id
);

    loader_state_t        state;
    packet_t              slots [NUM_SLOTS];
    logic                 transfer;
    logic                 id_ok;
    logic                 go_load;
    logic                 load_done;
    logic [NUM_SLOTS-1:0] wr_mask;
    logic [NUM_SLOTS-1:0] valid_next;

    assign in_ready = (state == FILL) && !clear;
    assign transfer = in_valid && in_ready;
    assign id_ok    = in_id < slot_id_t'(NUM_SLOTS);

    always_comb begin
        wr_mask = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (transfer && (slot_id_t'(i) == in_id)) begin
                wr_mask[i] = 1'b1;
            end
        end
    end

    // Decide on the post-write valid set so a completing write or write+commit loads this edge
    assign valid_next = slot_valid | wr_mask;
    assign go_load    = (state == FILL) && ((&valid_next) || (commit && (|valid_next)));

    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= FILL;
            slot_valid <= '0;
            bad_id     <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        if (wr_mask[i]) begin
                            slots[i] <= in_packet;
                        end
                    end
                    slot_valid <= valid_next;
                    bad_id     <= transfer && !id_ok;
                    if (go_load) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bad_id <= 1'b0;
                    if (load_done) begin
                        slot_valid <= '0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    load_strobe_gen #(
        .LOAD_CYCLES(LOAD_CYCLES)
    ) u_strobe (
        .clock  (clock),
        .clear  (clear),
        .start  (go_load),
        .load_n (load_n),
        .busy   (busy),
        .done   (load_done)
    );

    assign packet_out0 = slots[0];
    assign packet_out1 = slots[1];
    assign packet_out2 = slots[2];
    assign packet_out3 = slots[3];
    assign packet_out4 = slots[4];
    assign packet_out5 = slots[5];

endmodule

// File: tb/tb_packet_loader.sv
// Drives two loaders (1- and 3-cycle strobes) with shared stimulus against a slot-array model.
module tb_packet_loader;

    logic        clock = 1'b0;
    logic        clear;
    logic        in_valid;
    logic [3:0]  in_id;
    logic [23:0] in_packet;
    logic        commit;

    logic        in_ready [2];
    logic [23:0] po [2][6];
    logic        load_n [2];
    logic [5:0]  slot_valid [2];
    logic        busy [2];
    logic        bad_id [2];

    int errors = 0;
    int checks = 0;

    // Behavioural model: per instance, slot array, valid set, remaining strobe cycles
    logic [23:0] m_slot [2][6];
    logic [5:0]  m_valid [2];
    int          m_left [2];
    logic        m_bad [2];
    int          lcs [2] = '{1, 3};

    always #5 clock = ~clock;

    packet_loader #(.LOAD_CYCLES(1)) u_dut1 (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_id(in_id), .in_packet(in_packet), .commit(commit),
        .packet_out0(po[0][0]), .packet_out1(po[0][1]), .packet_out2(po[0][2]),
        .packet_out3(po[0][3]), .packet_out4(po[0][4]), .packet_out5(po[0][5]),
        .load_n(load_n[0]), .slot_valid(slot_valid[0]), .busy(busy[0]), .bad_id(bad_id[0])
    );

    packet_loader #(.LOAD_CYCLES(3)) u_dut3 (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_id(in_id), .in_packet(in_packet), .commit(commit),
        .packet_out0(po[1][0]), .packet_out1(po[1][1]), .packet_out2(po[1][2]),
        .packet_out3(po[1][3]), .packet_out4(po[1][4]), .packet_out5(po[1][5]),
        .load_n(load_n[1]), .slot_valid(slot_valid[1]), .busy(busy[1]), .bad_id(bad_id[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h at %0t", tag, lcs[k], obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input logic clr, input logic v, input logic [3:0] id,
                              input logic [23:0] pkt, input logic cm);
        if (clr) begin
            for (int s = 0; s < 6; s++) m_slot[k][s] = '0;
            m_valid[k] = '0;
            m_left[k]  = 0;
            m_bad[k]   = 1'b0;
        end else if (m_left[k] > 0) begin
            m_bad[k] = 1'b0;
            m_left[k]--;
            if (m_left[k] == 0) m_valid[k] = '0;
        end else begin
            m_bad[k] = 1'b0;
            if (v) begin
                if (int'(id) < 6) begin
                    m_slot[k][id]  = pkt;
                    m_valid[k][id] = 1'b1;
                end else begin
                    m_bad[k] = 1'b1;
                end
            end
            if (m_valid[k] == 6'h3F || (cm && m_valid[k] != 6'h00)) m_left[k] = lcs[k];
        end
    endtask

    task automatic cycle(input logic clr, input logic v, input logic [3:0] id,
                         input logic [23:0] pkt, input logic cm);
        clear = clr; in_valid = v; in_id = id; in_packet = pkt; commit = cm;
        #2;
        for (int k = 0; k < 2; k++)
            chk("in_ready", k, 32'(in_ready[k]), 32'(!clr && m_left[k] == 0));
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_edge(k, clr, v, id, pkt, cm);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("load_n", k, 32'(load_n[k]), 32'(m_left[k] == 0));
            chk("busy", k, 32'(busy[k]), 32'(m_left[k] > 0));
            chk("slot_valid", k, 32'(slot_valid[k]), 32'(m_valid[k]));
            chk("bad_id", k, 32'(bad_id[k]), 32'(m_bad[k]));
            for (int s = 0; s < 6; s++) chk("packet_out", k, 32'(po[k][s]), 32'(m_slot[k][s]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 24'h0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 4'd0, 24'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'd0, 24'h0, 1'b0);
    endtask

    initial begin
        clear = 1'b1; in_valid = 1'b0; in_id = '0; in_packet = '0; commit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = '0; m_left[k] = 0; m_bad[k] = 1'b0;
            for (int s = 0; s < 6; s++) m_slot[k][s] = '0;
        end
        @(posedge clock); #1;

        // Full set of six writes triggers the load on the id-5 edge
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 4'(i), 24'h000010 + 24'(i), 1'b0);
        chk("full_load_n", 0, 32'(load_n[0]), 32'd0);
        idle(4);
        for (int s = 0; s < 6; s++) chk("full_pkt", 0, 32'(po[0][s]), 32'h10 + 32'(s));
        chk("full_valid_after", 0, 32'(slot_valid[0]), 32'd0);

        // Partial commit, then a second round reloading stale slot 2
        do_reset();
        cycle(1'b0, 1'b1, 4'd2, 24'hABCDEF, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 24'h0, 1'b1);
        chk("commit_load_n", 0, 32'(load_n[0]), 32'd0);
        chk("commit_pkt2", 0, 32'(po[0][2]), 32'hABCDEF);
        chk("commit_pkt0", 0, 32'(po[0][0]), 32'h0);
        idle(4);
        cycle(1'b0, 1'b1, 4'd4, 24'h000001, 1'b1);
        chk("reload_pkt2", 0, 32'(po[0][2]), 32'hABCDEF);
        chk("reload_pkt4", 0, 32'(po[0][4]), 32'h000001);
        idle(4);

        // Overwrite of slot 3 before completion
        cycle(1'b0, 1'b1, 4'd3, 24'h111111, 1'b0);
        cycle(1'b0, 1'b1, 4'd3, 24'h222222, 1'b0);
        cycle(1'b0, 1'b1, 4'd0, 24'h000A00, 1'b0);
        cycle(1'b0, 1'b1, 4'd1, 24'h000A01, 1'b0);
        cycle(1'b0, 1'b1, 4'd2, 24'h000A02, 1'b0);
        cycle(1'b0, 1'b1, 4'd4, 24'h000A04, 1'b0);
        cycle(1'b0, 1'b1, 4'd5, 24'h000A05, 1'b0);
        chk("overwrite_pkt3", 0, 32'(po[0][3]), 32'h222222);
        idle(4);

        // Out-of-range id and empty commit
        cycle(1'b0, 1'b1, 4'd9, 24'h123456, 1'b0);
        chk("bad_id_pulse", 0, 32'(bad_id[0]), 32'd1);
        cycle(1'b0, 1'b0, 4'd0, 24'h0, 1'b1);
        chk("bad_id_clear", 0, 32'(bad_id[0]), 32'd0);
        chk("empty_commit", 0, 32'(load_n[0]), 32'd1);
        idle(2);

        // One write then commit, with in_valid held high through the load
        cycle(1'b0, 1'b1, 4'd0, 24'h0C0C0C, 1'b0);
        cycle(1'b0, 1'b0, 4'd0, 24'h0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'd1, 24'h777000 + 24'(i), 1'b0);
        idle(4);

        // Clear on the second cycle of a 3-cycle load
        cycle(1'b0, 1'b1, 4'd5, 24'h5A5A5A, 1'b1);
        cycle(1'b0, 1'b0, 4'd0, 24'h0, 1'b0);
        chk("mid_load_busy", 1, 32'(load_n[1]), 32'd0);
        cycle(1'b1, 1'b0, 4'd0, 24'h0, 1'b0);
        chk("mid_clear_load_n", 1, 32'(load_n[1]), 32'd1);
        chk("mid_clear_pkt5", 1, 32'(po[1][5]), 32'd0);
        cycle(1'b0, 1'b0, 4'd0, 24'h0, 1'b0);
        chk("after_clear_ready", 1, 32'(in_ready[1]), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       r_clr;
            logic       r_v;
            logic [3:0] r_id;
            logic       r_cm;
            r_clr = ($urandom_range(0, 59) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_id  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
            r_cm  = ($urandom_range(0, 7) == 0);
            cycle(r_clr, r_v, r_id, 24'($urandom), r_cm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
